// File: rtl/mux_sel_arb_if.sv
// Request/grant bundle between two source channels, the arbiter and the 2:1 mux stage.
interface mux_sel_arb_if;
  logic [1:0] req;
  logic [1:0] last;
  logic       ready;
  logic       sel;
  logic [1:0] gnt;
  logic       vld;
  logic       preempt;

  // Source/downstream side: drives requests and ready, observes the grant.
  modport master (
    output req, last, ready,
    input  sel, gnt, vld, preempt
  );

  // Arbiter side.
  modport slave (
    input  req, last, ready,
    output sel, gnt, vld, preempt
  );
endinterface

// File: rtl/mux_sel_arb.sv
// Two-channel round-robin packet arbiter driving the select of a downstream 2:1 mux.
// A grant is held for a whole packet; a beat limit forces rotation when the other
// channel is waiting.
module mux_sel_arb #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_sel_arb_if.slave  bus_io
);

  localparam int unsigned       CntW   = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0]   CntMax = CntW'(MAX_HOLD - 1);

  // Grant states are encoded one-hot so the state register is the grant vector.
  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StG0   = 2'b01;
  localparam logic [1:0] StG1   = 2'b10;

  logic [1:0]      state_q, state_d;
  logic            sel_q, sel_d;
  logic            ptr_q, ptr_d;
  logic            pre_q, pre_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic cur, oth, xfer, at_limit, rel_last, rel_force, rel, k;

  assign cur       = state_q[1];
  assign oth       = ~cur;
  assign bus_io.vld = |(state_q & bus_io.req);
  assign xfer      = bus_io.vld & bus_io.ready;
  assign at_limit  = (cnt_q == CntMax);
  assign rel_last  = bus_io.last[cur];
  assign rel_force = at_limit & bus_io.req[oth];
  assign rel       = xfer & (rel_last | rel_force);

  assign bus_io.gnt     = state_q;
  assign bus_io.sel     = sel_q;
  assign bus_io.preempt = pre_q;

  // Next-state: grant from idle, hold through the packet, release/rotate on the last
  // or limit beat.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    k       = 1'b0;
    case (state_q)
      StIdle: begin
        if (|bus_io.req) begin
          // Tie goes to the pointer, otherwise the sole requester.
          k       = (&bus_io.req) ? ptr_q : bus_io.req[1];
          state_d = k ? StG1 : StG0;
          sel_d   = k;
          cnt_d   = '0;
        end
      end
      StG0, StG1: begin
        if (rel) begin
          ptr_d = oth;
          cnt_d = '0;
          // A beat that is both last and at the limit counts as a normal release.
          pre_d = rel_force & ~rel_last;
          if (bus_io.req[oth]) begin
            state_d = oth ? StG1 : StG0;
            sel_d   = oth;
          end else if (!bus_io.req[cur]) begin
            state_d = StIdle;
          end
        end else if (xfer && !at_limit) begin
          // Saturates at the limit while the other channel stays quiet.
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
      pre_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Scoreboard bench for mux_sel_arb: two instances (beat limits 4 and 1) share the
// stimulus; a packet-level reference model predicts each cycle's outputs into queues
// that a negedge monitor drains and compares.
module tb_mux_sel_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_sel_arb_if if_a ();
  mux_sel_arb_if if_b ();

  mux_sel_arb #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus_io(if_a));
  mux_sel_arb #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus_io(if_b));

  typedef struct packed {
    logic [1:0] gnt;
    logic       sel;
    logic       vld;
    logic       pre;
  } exp_t;

  // Packet-level view: who owns the mux (-1 = nobody), beats sent this grant.
  typedef struct {
    int owner;
    int beats;
    bit ptr;
    bit sel;
    bit pre;
  } mstate_t;

  exp_t    qa[$], qb[$];
  mstate_t ma, mb;
  int      checks = 0;
  int      errors = 0;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.owner = -1; s.beats = 0; s.ptr = 1'b0; s.sel = 1'b0; s.pre = 1'b0;
    return s;
  endfunction

  function automatic exp_t predict(mstate_t s, logic [1:0] rq);
    exp_t e;
    e.gnt = (s.owner < 0) ? 2'b00 : ((s.owner == 1) ? 2'b10 : 2'b01);
    e.sel = s.sel;
    e.vld = (s.owner >= 0) && rq[s.owner];
    e.pre = s.pre;
    return e;
  endfunction

  function automatic mstate_t step(int hold, mstate_t s, logic r, logic [1:0] rq,
                                   logic [1:0] ls, logic rd);
    mstate_t n = s;
    int i, o;
    bit limit;
    if (!r) return reset_state();
    n.pre = 1'b0;
    if (s.owner < 0) begin
      if (rq != 2'b00) begin
        n.owner = (rq == 2'b11) ? int'(s.ptr) : (rq[1] ? 1 : 0);
        n.sel   = (n.owner == 1);
        n.beats = 0;
      end
    end else begin
      i = s.owner;
      o = 1 - i;
      if (rq[i] && rd) begin
        limit = (s.beats + 1 >= hold) && rq[o];
        if (ls[i] || limit) begin
          n.pre   = !ls[i];
          n.ptr   = (o == 1);
          n.beats = 0;
          if (rq[o]) begin
            n.owner = o;
            n.sel   = (o == 1);
          end else if (!rq[i]) begin
            n.owner = -1;
          end
        end else begin
          n.beats = s.beats + 1;
        end
      end
    end
    return n;
  endfunction

  // One clock: apply inputs, queue the outputs expected this cycle, advance the models.
  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] ls,
                       input logic rd);
    rst_n = r;
    if_a.req = rq; if_a.last = ls; if_a.ready = rd;
    if_b.req = rq; if_b.last = ls; if_b.ready = rd;
    qa.push_back(predict(ma, rq));
    qb.push_back(predict(mb, rq));
    ma = step(4, ma, r, rq, ls, rd);
    mb = step(1, mb, r, rq, ls, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input exp_t e, input exp_t g);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b sel=%b vld=%b preempt=%b want gnt=%b sel=%b vld=%b preempt=%b",
               nm, $time, g.gnt, g.sel, g.vld, g.pre, e.gnt, e.sel, e.vld, e.pre);
    end
  endtask

  // Monitor: every cycle the arbiters present outputs; compare away from the edge.
  always @(negedge clk) begin
    exp_t e, g;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = {if_a.gnt, if_a.sel, if_a.vld, if_a.preempt};
      check_out("hold4", e, g);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = {if_b.gnt, if_b.sel, if_b.vld, if_b.preempt};
      check_out("hold1", e, g);
    end
  end

  initial begin
    ma = reset_state();
    mb = reset_state();
    // Unchecked first edge: outputs are unknown until reset is sampled once.
    rst_n = 1'b0;
    if_a.req = 2'b11; if_a.last = 2'b00; if_a.ready = 1'b1;
    if_b.req = 2'b11; if_b.last = 2'b00; if_b.ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with both requesting, then release: channel 0 wins on ptr.
    repeat (3) drive(1'b0, 2'b11, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 2'b01, 1'b1);
    drive(1'b1, 2'b00, 2'b00, 1'b1);
    repeat (2) drive(1'b1, 2'b00, 2'b00, 1'b1);

    // Single channel 1, 4-beat packet, then idle with sel held.
    drive(1'b1, 2'b10, 2'b00, 1'b1);
    repeat (3) drive(1'b1, 2'b10, 2'b00, 1'b1);
    drive(1'b1, 2'b10, 2'b10, 1'b1);
    repeat (3) drive(1'b1, 2'b00, 2'b00, 1'b1);

    // Round robin with 2-beat packets on both channels.
    for (int c = 0; c < 10; c++) drive(1'b1, 2'b11, (c % 2) ? 2'b00 : 2'b11, 1'b1);
    repeat (3) drive(1'b1, 2'b00, 2'b00, 1'b1);

    // Forced rotation: long channel 0 packet, channel 1 joins two cycles in.
    repeat (2) drive(1'b1, 2'b01, 2'b00, 1'b1);
    for (int c = 0; c < 8; c++) drive(1'b1, 2'b11, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 2'b10, 1'b1);
    for (int c = 0; c < 6; c++) drive(1'b1, 2'b01, (c == 5) ? 2'b01 : 2'b00, 1'b1);
    repeat (2) drive(1'b1, 2'b00, 2'b00, 1'b1);

    // Backpressure on a granted channel, then resume.
    drive(1'b1, 2'b01, 2'b00, 1'b1);
    repeat (5) drive(1'b1, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 2'b01, 2'b00, 1'b1);
    drive(1'b1, 2'b01, 2'b01, 1'b1);
    repeat (2) drive(1'b1, 2'b00, 2'b00, 1'b1);

    // Reset mid-packet, then both request: granted from idle with ptr back at 0.
    repeat (3) drive(1'b1, 2'b10, 2'b00, 1'b1);
    drive(1'b0, 2'b10, 2'b00, 1'b1);
    repeat (3) drive(1'b1, 2'b11, 2'b00, 1'b1);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(199) != 0), 2'($urandom), 2'($urandom),
            ($urandom_range(3) != 0));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arb.md
# mux_sel_arb

Two-channel round-robin arbiter that drives the select and data-valid for the downstream 2:1 mux stage. It grants one of two requesting channels for the duration of a packet, holds the mux select stable while the packet streams, and rotates priority on packet end. A beat limit forces rotation so a long packet cannot starve the other channel.

## Interface
Parameters:
- MAX_HOLD, 16: maximum beats per grant before forced rotation when the other channel is requesting. Legal range is 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- req  input  2  req[i] = channel i has a beat available.
- last  input  2  last[i] = the current beat of channel i ends its packet. Ignored unless that beat transfers.
- ready  input  1  downstream accepts the beat this cycle.
- sel  output  1  mux select; registered; 0 selects channel 0, 1 selects channel 1.
- gnt  output  2  one-hot grant; registered; 2'b00 when idle.
- vld  output  1  beat present at the mux output; vld = |(gnt & req).
- preempt  output  1  one-cycle registered pulse marking a forced rotation.

## Operation
- Internal state:
  - FSM with states IDLE, G0, G1.
  - Priority pointer ptr (1 bit). The channel indexed by ptr wins ties.
  - Beat counter cnt, width clog2(MAX_HOLD+1).
- Transfer: a beat transfers in a cycle when vld && ready.
- IDLE:
  - gnt = 00.
  - If req != 0, move to G(k) next cycle.
  - k is the sole requester. If both channels request, k = ptr.
  - sel <= k and cnt <= 0 on the same edge.
- G(i):
  - gnt[i] = 1 and sel = i, both held constant.
  - On each transfer, cnt <= cnt+1.
  - If req[i] drops mid-packet, the grant is held and vld = 0. Packets are atomic.
- Release occurs on a transfer that meets either condition:
  - (a) last[i] = 1, or
  - (b) cnt == MAX_HOLD-1 and req[~i] = 1. This is a forced rotation: preempt <= 1 for one cycle. The remainder of channel i's packet resumes on its next grant.
- On release:
  - ptr <= ~i and cnt <= 0.
  - Next state is G(~i) if req[~i] = 1 in the release cycle. This is a back-to-back grant with no idle bubble.
  - Otherwise, next state is G(i) if req[i] = 1 (a new packet from the same channel).
  - Otherwise, next state is IDLE.
- When cnt reaches MAX_HOLD-1 while req[~i] = 0, there is no preemption. cnt saturates at MAX_HOLD-1 until a release.
- sel changes only on a grant change. It holds its last value through IDLE.

## Timing
- Reset values (rst_n low at an edge): state IDLE, gnt 00, sel 0, ptr 0, cnt 0, preempt 0. vld is 0 as a consequence of gnt = 00.
- Reset mid-packet aborts the grant with no completion.
- Latency:
  - req rising in IDLE to gnt/sel valid: 1 cycle.
  - Handover from a release beat to the next grant: 0 bubble cycles. The new gnt/sel appear the cycle after the release beat.
- vld is combinational from req and registered gnt. It has no combinational path from ready.
- Simultaneous events:
  - last and forced-rotation conditions in the same beat: treat as a normal release, preempt = 0.
  - req of both channels arriving in IDLE together: ptr decides.
- MAX_HOLD = 1: every transfer releases when the other channel requests. This gives strict alternation.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with req = 11 -> gnt = 00, sel = 0, vld = 0, preempt = 0 throughout. Release reset -> gnt = 01 the following cycle (ptr = 0).
- Single channel: req = 10, 4 beats, ready = 1, last on beat 4 -> gnt = 10 and sel = 1 for exactly 4 transfers, then IDLE. sel stays 1 in IDLE.
- Round robin: req = 11 steady, 2-beat packets on both channels, ready = 1 -> grants alternate 01, 10, 01 with no idle cycle between packets.
- Forced rotation: MAX_HOLD = 4, channel 0 sends a 10-beat packet, channel 1 requests from cycle 2 -> channel 0 gets 4 beats, then preempt pulses for 1 cycle, then gnt = 10. Channel 0 resumes after channel 1's last.
- Backpressure: granted channel with ready = 0 for 5 cycles -> cnt, gnt and sel are unchanged and vld = 1. Transfers resume when ready = 1.
- Reset mid-packet: rst_n = 0 on beat 2 of 6 -> the next cycle shows gnt = 00 and ptr = 0. The next request is granted from IDLE.
